out_port_uart_tx: RTL and testbench

//  Serial transmitter on the Mips OutPort side. Captures each 16-bit word the core

---
 rtl/out_port_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_out_port_uart_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_uart_tx.sv
// OutPort serial transmitter: buffers 16-bit core writes in a FIFO and sends each
// word as two 8N1 UART frames (low byte first) on a registered tx line.
module out_port_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] out_data,
  input  logic        out_we,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        overflow,
  output logic        tx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q, busy_q, ovf_q, ovf_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             byte_q, byte_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             tx_q, tx_d;

  logic             wr_en;
  logic             pop;
  logic             bit_end;

  // Writes are gated by the registered full flag, so a same-cycle pop never frees a slot.
  assign wr_en   = out_we & ~full_q;
  assign bit_end = (clk_cnt_q == BIT_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (out_we & full_q);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          byte_d  = 1'b0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_d     = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          // After eight shifts of the low byte, the high byte sits in bits [7:0].
          shreg_d   = {1'b0, shreg_q[15:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = START;
          end else if (!empty_q) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            byte_d  = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      byte_q    <= 1'b0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= (count_d == DEPTH_C);
      empty_q   <= (count_d == '0);
      busy_q    <= (state_d != IDLE) | (count_d != '0);
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Scoreboard bench for out_port_uart_tx: a timeline model predicts FIFO acceptance,
// flags and the byte/start-cycle of every frame; a UART receiver checks tx.
module tb_out_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int WORD  = 20 * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] out_data = '0;
  logic        out_we = 1'b0;
  logic        full, empty, busy, overflow, tx;

  out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .out_data (out_data),
    .out_we   (out_we),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    int unsigned c;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned acc_q[$];
  int unsigned pop_q[$];
  int unsigned free_at = 0;
  int unsigned last_pop = 0;
  bit          model_ovf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endfunction

  // Words leave the FIFO one per word-time; a word is accepted iff fewer than DEPTH
  // accepted words are still waiting to be popped at the write edge.
  function automatic void model_write(input int unsigned n, input logic [15:0] d);
    int unsigned waiting = 0;
    int unsigned p;
    foreach (acc_q[i]) if (acc_q[i] < n && pop_q[i] >= n) waiting++;
    if (waiting < DEPTH) begin
      p = (n + 1 > free_at) ? n + 1 : free_at;
      free_at = p + WORD;
      last_pop = p;
      acc_q.push_back(n);
      pop_q.push_back(p);
      exp_q.push_back('{b: d[7:0],  c: p});
      exp_q.push_back('{b: d[15:8], c: p + WORD / 2});
    end else begin
      model_ovf = 1'b1;
    end
  endfunction

  function automatic void check_flags();
    int unsigned n = cyc;
    int unsigned cnt = 0;
    bit active = 1'b0;
    foreach (acc_q[i]) begin
      if (acc_q[i] <= n && pop_q[i] > n) cnt++;
      if (pop_q[i] <= n && n < pop_q[i] + WORD) active = 1'b1;
    end
    chk("empty", empty, cnt == 0);
    chk("full", full, cnt == DEPTH);
    chk("busy", busy, active || cnt != 0);
    chk("overflow", overflow, model_ovf);
  endfunction

  task automatic step(input logic we, input logic [15:0] d);
    @(negedge clock);
    if (reset) check_flags();
    out_we   = we;
    out_data = d;
    if (we && reset) model_write(cyc + 1, d);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && cyc > free_at + 1) break;
      step(1'b0, 16'($urandom));
    end
    chk("drain_pending", exp_q.size(), 0);
    step(1'b0, 16'h0);
    chk("idle_busy", busy, 0);
    chk("idle_empty", empty, 1);
    chk("idle_tx", tx, 1);
  endtask

  task automatic rx_frame(input int unsigned s);
    logic [9:0] bits;
    bit aborted;
    exp_t e;
    aborted = 1'b0;
    bits = '0;
    for (int k = 0; k < 10; k++) begin
      int w;
      w = (k == 0) ? CPB / 2 : CPB;
      for (int j = 0; j < w; j++) begin
        @(negedge clock);
        if (!reset) aborted = 1'b1;
      end
      if (aborted) break;
      bits[k] = tx;
    end
    if (aborted) return;
    chk("start_bit", bits[0], 0);
    chk("stop_bit", bits[9], 1);
    if (exp_q.size() == 0) begin
      chk("unexpected_frame", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("frame_byte", bits[8:1], e.b);
      chk("frame_start_cycle", s, e.c);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset && tx === 1'b0) rx_frame(cyc);
    end
  end

  initial begin
    int unsigned p;
    int gap;

    @(negedge clock);
    @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    #2 reset = 1'b1;

    step(1'b0, 16'h0);
    step(1'b0, 16'h0);

    // Single word: two frames of 0xAA
    step(1'b1, 16'hAAAA);
    drain();

    // Back-to-back words, no gap between the four frames
    step(1'b1, 16'h1234);
    step(1'b1, 16'h00FF);
    drain();

    // Fill while busy: four accepted, fifth dropped and flagged
    step(1'b1, 16'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom));
    step(1'b0, 16'h0);
    chk("full_after_fill", full, 1);
    chk("overflow_after_fill", overflow, 1);
    drain();

    // Write landing on the same edge as a pop with one word queued
    step(1'b1, 16'hC0DE);
    step(1'b1, 16'hBEEF);
    for (int i = 0; i < 200; i++) begin
      if (cyc + 1 >= last_pop) break;
      step(1'b0, 16'h0);
    end
    step(1'b1, 16'h5A3C);
    drain();

    // Reset in the middle of the high byte's data bits
    step(1'b1, 16'hF00D);
    p = last_pop;
    for (int i = 0; i < 200; i++) begin
      if (cyc >= p + WORD / 2 + CPB + 6) break;
      step(1'b0, 16'h0);
    end
    #2 reset = 1'b0;
    out_we = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_overflow", overflow, 0);
    exp_q.delete();
    acc_q.delete();
    pop_q.delete();
    free_at = 0;
    model_ovf = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    step(1'b1, 16'h0055);
    drain();

    // out_data wiggling without a strobe is ignored
    for (int i = 0; i < 100; i++) step(1'b0, 16'($urandom));
    chk("nowe_empty", empty, 1);
    chk("nowe_tx", tx, 1);

    // Random traffic with bursts and idle gaps
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 16'($urandom));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 90));
      for (int j = 0; j < gap; j++) step(1'b0, 16'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
